rotary_event_gen: RTL
=====================

Name: rotary_event_gen

Overview:
- Front end for the rotary-encoder operand-entry path.
- Converts the raw quadrature contacts (rot_a, rot_b) into the clean `rotation_event` level and `rotation_direction` flag that the operand-capture logic edge-detects.
- Also provides a one-cycle step strobe and a wrapping signed position count for LED/debug use.
- Sits between the board encoder pins and the operand collector.

Parameters:
- DEBOUNCE_CYCLES, 16, number of consecutive cycles a synchronized contact level must hold before it is accepted; valid range 1..65535.
- POS_W, 8, width of the position counter (two's complement).

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- rot_a  input  1  raw encoder contact A, asynchronous to clk.
- rot_b  input  1  raw encoder contact B, asynchronous to clk.
- rotation_event  output  1  filtered detent level (q1); consumers act on its 0->1 edge.
- rotation_direction  output  1  1 = clockwise, 0 = counter-clockwise; updated on each q1 rising edge.
- step_pulse  output  1  single-cycle strobe, one per detent.
- position  output  POS_W  signed detent count; +1 clockwise, -1 counter-clockwise.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - Clears both 2-FF synchronizers, debounce counters and accepted levels to 0.
  - Sets q1=0, q2=0, q1_prev=0.
  - Sets rotation_event=0, rotation_direction=0, step_pulse=0, position=0.
  - Reset wins over any concurrent input activity.
  - Reset mid-rotation discards the partial detent; no step is emitted for it.
- Synchronization: rot_a and rot_b each pass through two flops before any other use.
- Debounce (when enabled), per contact:
  - If synced value != accepted value, increment that contact's counter.
  - When the counter reaches DEBOUNCE_CYCLES-1 and the values still differ, update the accepted value and clear the counter.
  - Any cycle where synced == accepted clears the counter.
  - A glitch shorter than DEBOUNCE_CYCLES cycles never changes the accepted level.
- Quadrature filter, evaluated every cycle on {acc_b, acc_a}:
  - 00: q1<=0, q2 holds.
  - 01: q2<=0, q1 holds.
  - 10: q2<=1, q1 holds.
  - 11: q1<=1, q2 holds.
- Outputs:
  - rotation_event = q1, registered.
  - q1_prev <= q1 every cycle.
  - When q1=1 and q1_prev=0:
    - step_pulse<=1 for exactly one cycle.
    - rotation_direction<=q2.
    - position<=position+1 if q2=1, else position-1.
  - Otherwise step_pulse<=0, and rotation_direction and position hold.
- Position arithmetic: modulo 2^POS_W.
  - With POS_W=8, 127+1 -> -128 and -128-1 -> 127.
  - No saturation, no overflow flag.
- Latency (debounce disabled):
  - Pin change at edge k is synchronized at k+2.
  - q1/q2 update at k+3.
  - step_pulse, rotation_direction and position update at k+4.
- Latency (debounce enabled): add DEBOUNCE_CYCLES cycles.
- Simultaneous change of both contacts in one cycle is resolved by the table above; no error signalled.
- Contact bounce around the 11 or 00 state cannot produce a second q1 rising edge, because q1 only changes in states 00 and 11.
- Minimum spacing between step_pulses is 2 cycles.

Optional Feature:
- Macro: ROT_DEBOUNCE_EN.
- Defined: the per-contact debounce counters and accepted-level registers are built, with behaviour as above, and DEBOUNCE_CYCLES applies.
- Undefined: the accepted levels equal the synchronizer outputs directly, no counters are instantiated, and DEBOUNCE_CYCLES is ignored.
- Quadrature filter and output behaviour are identical in both builds.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles with rot_a=rot_b=1 -> all outputs 0 during reset; rotation_event rises only after release plus pipeline latency.
- Clockwise detent: {b,a} sequence 00->10->11, each held 40 cycles -> exactly one step_pulse; rotation_direction=1; position 0->1; rotation_event 0->1.
- Counter-clockwise detent: {b,a} sequence 00->01->11 -> one step_pulse; rotation_direction=0; position 0->-1 (0xFF).
- Bounce, ROT_DEBOUNCE_EN defined, DEBOUNCE_CYCLES=16: from 11 toggle rot_a 0/1 every 3 cycles for 30 cycles, then settle at 1 -> no step_pulse, position unchanged.
- Wrap: 127 clockwise detents from 0 -> position=127; one more -> position=-128 (0x80); then one counter-clockwise detent -> 127.
- Reset mid-rotation: enter state 10, assert rst_n=0 for 1 cycle, then go to 11 -> the first rising q1 after reset yields step_pulse with rotation_direction=0 (q2 was cleared) and position=-1; the next full clockwise detent gives position=0.

Source files
------------

// File: rtl/rotary_event_gen.sv
// -----------------------------------------------------------------------------
// rotary_event_gen
//
// Front end for the rotary-encoder operand-entry path. The raw quadrature
// contacts are synchronized, optionally debounced, and passed through a
// quadrature latch filter. The filter produces q1, the detent level, and q2,
// the direction memory. The outputs are:
//   - rotation_event     : registered copy of q1. Consumers edge-detect 0->1.
//   - rotation_direction : 1 = clockwise. Loaded from q2 on each q1 rising edge.
//   - step_pulse         : one-cycle strobe per detent.
//   - position           : wrapping two's-complement detent count.
//
// Ports:
//   clk                 in   system clock, rising edge
//   rst_n               in   synchronous active-low reset
//   rot_a, rot_b        in   raw encoder contacts (asynchronous to clk)
//   rotation_event      out  filtered detent level
//   rotation_direction  out  direction of the last detent
//   step_pulse          out  one strobe per detent
//   position            out  signed detent count, POS_W bits
//
// Build option:
//   ROT_DEBOUNCE_EN  When defined, each contact gets a debounce counter and
//                    an accepted-level register. A level is accepted only
//                    after it has held for DEBOUNCE_CYCLES cycles. When
//                    undefined, the synchronizer outputs are used directly
//                    and DEBOUNCE_CYCLES has no effect.
// -----------------------------------------------------------------------------
module rotary_event_gen #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int POS_W           = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    rot_a,
    input  logic                    rot_b,
    output logic                    rotation_event,
    output logic                    rotation_direction,
    output logic                    step_pulse,
    output logic signed [POS_W-1:0] position
);

    // Reject an out-of-range debounce length at elaboration time.
    if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > 65535) begin : g_bad_debounce
        $error("DEBOUNCE_CYCLES must be in 1..65535");
    end

    // Bit 1 = contact B, bit 0 = contact A. This matches the {b,a} filter table.
    logic [1:0] raw;
    logic [1:0] acc;

    assign raw = {rot_b, rot_a};

    // -------------------------------------------------------------------------
    // Per-contact synchronizer and (optional) debounce
    // -------------------------------------------------------------------------
    for (genvar gi = 0; gi < 2; gi++) begin : g_contact
        logic s1_q, s1_d;
        logic s2_q, s2_d;

        always_comb begin
            s1_d = raw[gi];
            s2_d = s1_q;
        end

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                s1_q <= 1'b0;
                s2_q <= 1'b0;
            end else begin
                s1_q <= s1_d;
                s2_q <= s2_d;
            end
        end

`ifdef ROT_DEBOUNCE_EN
        localparam logic [15:0] DB_MAX = 16'(DEBOUNCE_CYCLES - 1);

        logic        acc_q, acc_d;
        logic [15:0] cnt_q, cnt_d;

        // The counter runs only while the synced level disagrees with the
        // accepted level. Any agreeing cycle restarts it, so a glitch shorter
        // than DEBOUNCE_CYCLES cycles can never reach DB_MAX.
        always_comb begin
            acc_d = acc_q;
            cnt_d = '0;
            if (s2_q != acc_q) begin
                if (cnt_q == DB_MAX) begin
                    acc_d = s2_q;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
        end

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                acc_q <= 1'b0;
                cnt_q <= '0;
            end else begin
                acc_q <= acc_d;
                cnt_q <= cnt_d;
            end
        end

        assign acc[gi] = acc_q;
`else
        assign acc[gi] = s2_q;
`endif
    end

    // -------------------------------------------------------------------------
    // Quadrature latch filter
    // -------------------------------------------------------------------------
    // q1 changes only in the 00 and 11 states. Bounce on one contact near a
    // rest state can therefore never create a second q1 rising edge.
    logic q1_q, q1_d;
    logic q2_q, q2_d;

    always_comb begin
        q1_d = q1_q;
        q2_d = q2_q;
        case (acc)
            2'b00:   q1_d = 1'b0;
            2'b01:   q2_d = 1'b0;
            2'b10:   q2_d = 1'b1;
            default: q1_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q1_q <= 1'b0;
            q2_q <= 1'b0;
        end else begin
            q1_q <= q1_d;
            q2_q <= q2_d;
        end
    end

    // -------------------------------------------------------------------------
    // Event, step, direction and position
    // -------------------------------------------------------------------------
    logic                    q1_prev_q, q1_prev_d;
    logic                    event_q, event_d;
    logic                    step_q, step_d;
    logic                    dir_q, dir_d;
    logic signed [POS_W-1:0] pos_q, pos_d;
    logic                    q1_rise;

    assign q1_rise = q1_q & ~q1_prev_q;

    always_comb begin
        q1_prev_d = q1_q;
        event_d   = q1_q;
        step_d    = 1'b0;
        dir_d     = dir_q;
        pos_d     = pos_q;
        if (q1_rise) begin
            step_d = 1'b1;
            dir_d  = q2_q;
            // Plain modulo-2^POS_W arithmetic: the count wraps, no saturation.
            if (q2_q) begin
                pos_d = pos_q + POS_W'(1);
            end else begin
                pos_d = pos_q - POS_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q1_prev_q <= 1'b0;
            event_q   <= 1'b0;
            step_q    <= 1'b0;
            dir_q     <= 1'b0;
            pos_q     <= '0;
        end else begin
            q1_prev_q <= q1_prev_d;
            event_q   <= event_d;
            step_q    <= step_d;
            dir_q     <= dir_d;
            pos_q     <= pos_d;
        end
    end

    assign rotation_event     = event_q;
    assign rotation_direction = dir_q;
    assign step_pulse         = step_q;
    assign position           = pos_q;

endmodule
